// File: rtl/writeback_unit_if.sv
// Writeback stage bundle: ALU and load completion streams in, register-file write port and queue occupancy out.
interface writeback_unit_if #(
  parameter int LQ_DEPTH = 4
);
  localparam int CNT_W = $clog2(LQ_DEPTH + 1);

  logic             alu_valid;
  logic             alu_ready;
  logic [4:0]       alu_rd;
  logic [63:0]      alu_result;

  logic             mem_valid;
  logic             mem_ready;
  logic [4:0]       mem_rd;
  logic [63:0]      mem_data;
  logic [2:0]       mem_funct3;
  logic [2:0]       mem_offset;

  logic             write_sig;
  logic [4:0]       write_reg;
  logic [63:0]      write_val;
  logic [CNT_W-1:0] lq_count;

  // The producer/consumer side (issue stage, memory, register file).
  modport master (
    output alu_valid, alu_rd, alu_result,
    output mem_valid, mem_rd, mem_data, mem_funct3, mem_offset,
    input  alu_ready, mem_ready,
    input  write_sig, write_reg, write_val, lq_count
  );

  // The writeback unit itself.
  modport slave (
    input  alu_valid, alu_rd, alu_result,
    input  mem_valid, mem_rd, mem_data, mem_funct3, mem_offset,
    output alu_ready, mem_ready,
    output write_sig, write_reg, write_val, lq_count
  );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: merges single-cycle ALU results with late load results into one register-file write per cycle,
// with a small load queue and a bounded-starvation arbiter that favours load drain.
module writeback_unit #(
  parameter int LQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              reset,
  writeback_unit_if.slave  wb
);
  localparam int CNT_W = $clog2(LQ_DEPTH + 1);
  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

  logic [4:0]       lq_rd  [LQ_DEPTH];
  logic [63:0]      lq_val [LQ_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [ST_W-1:0]  starve;

  logic [63:0]      shifted;
  logic [63:0]      load_value;
  logic             lq_empty;
  logic             lq_full;
  logic             at_limit;
  logic             push;
  logic             grant_alu;
  logic             grant_lq;

  logic             write_sig_q;
  logic [4:0]       write_reg_q;
  logic [63:0]      write_val_q;

  // Lane extraction happens before enqueue so the queue holds register-ready values.
  always_comb begin
    shifted    = wb.mem_data >> {wb.mem_offset, 3'b000};
    load_value = shifted;
    case (wb.mem_funct3)
      3'b000:  load_value = {{56{shifted[7]}},  shifted[7:0]};
      3'b001:  load_value = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  load_value = {{32{shifted[31]}}, shifted[31:0]};
      3'b100:  load_value = {56'd0, shifted[7:0]};
      3'b101:  load_value = {48'd0, shifted[15:0]};
      3'b110:  load_value = {32'd0, shifted[31:0]};
      default: load_value = shifted;
    endcase
  end

  assign lq_empty  = (count == '0);
  assign lq_full   = (count == CNT_W'(LQ_DEPTH));
  assign at_limit  = (starve == ST_W'(STARVE_LIMIT));

  assign wb.alu_ready = !reset && (lq_empty || at_limit);
  assign wb.mem_ready = !reset && !lq_full;
  assign grant_alu    = wb.alu_valid && (lq_empty || at_limit);
  assign grant_lq     = !lq_empty && !grant_alu;
  assign push         = wb.mem_valid && wb.mem_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      lq_rd[tail]  <= wb.mem_rd;
      lq_val[tail] <= load_value;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)
        tail <= tail + PTR_W'(1);
      if (grant_lq)
        head <= head + PTR_W'(1);
      case ({push, grant_lq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      starve <= '0;
    else if (grant_alu || !wb.alu_valid)
      starve <= '0;
    else if (grant_lq && !at_limit)
      starve <= starve + ST_W'(1);
  end

  // x0 writes still consume the grant and update reg/val, but never raise the write enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_sig_q <= 1'b0;
      write_reg_q <= '0;
      write_val_q <= '0;
    end else if (grant_alu) begin
      write_sig_q <= (wb.alu_rd != 5'd0);
      write_reg_q <= wb.alu_rd;
      write_val_q <= wb.alu_result;
    end else if (grant_lq) begin
      write_sig_q <= (lq_rd[head] != 5'd0);
      write_reg_q <= lq_rd[head];
      write_val_q <= lq_val[head];
    end else begin
      write_sig_q <= 1'b0;
    end
  end

  assign wb.write_sig = write_sig_q;
  assign wb.write_reg = write_reg_q;
  assign wb.write_val = write_val_q;
  assign wb.lq_count  = count;
endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: accepted results go into per-source expected queues and are matched
// against register-file writes as they appear.
module tb_writeback_unit;
  localparam int LQ_DEPTH     = 4;
  localparam int STARVE_LIMIT = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] val;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  int   vectors_applied = 0;
  int   miscompares     = 0;
  int   alu_i           = 0;
  int   load_i          = 0;
  wr_t  exp_alu_q[$];
  wr_t  exp_load_q[$];

  logic [2:0]  f3_tab  [9] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd6, 3'd3, 3'd7, 3'd0};
  logic [2:0]  off_tab [9] = '{3'd6, 3'd6, 3'd6, 3'd6, 3'd4, 3'd4, 3'd7, 3'd0, 3'd7};
  logic [63:0] ext_tab [9] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_00FF,
                               64'hFFFF_FFFF_FFFF_80FF, 64'h0000_0000_0000_80FF,
                               64'hFFFF_FFFF_80FF_0000, 64'h0000_0000_80FF_0000,
                               64'h0000_0000_0000_0080, 64'h80FF_0000_0000_0000,
                               64'hFFFF_FFFF_FFFF_FF80};

  always #5 clk = ~clk;

  writeback_unit_if #(.LQ_DEPTH(LQ_DEPTH)) wb ();

  writeback_unit #(.LQ_DEPTH(LQ_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb)
  );

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors_applied++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic av, input logic [4:0] ard, input logic [63:0] ares,
                                input logic mv, input logic [4:0] mrd, input logic [63:0] mdata,
                                input logic [2:0] f3, input logic [2:0] off);
    @(posedge clk);
    #1;
    wb.alu_valid  = av;
    wb.alu_rd     = ard;
    wb.alu_result = ares;
    wb.mem_valid  = mv;
    wb.mem_rd     = mrd;
    wb.mem_data   = mdata;
    wb.mem_funct3 = f3;
    wb.mem_offset = off;
  endtask

  task automatic apply_idle();
    apply_stimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 3'd0, 3'd0);
  endtask

  // Both streams held valid every cycle; ALU rds stay in 1..15 and load rds in 16..31 so the monitor can tell them apart.
  task automatic run_stream(input int ncycles);
    for (int k = 0; k < ncycles; k++) begin
      apply_stimulus(1'b1, 5'(1 + alu_i % 15), 64'hA000_0000 + 64'(alu_i),
                     1'b1, 5'(16 + load_i % 16), 64'hB000_0000 + 64'(load_i), 3'd3, 3'd0);
      @(negedge clk);
      check_output($sformatf("alu_ready[%0d]", k), 64'(wb.alu_ready), 64'((k % 5) == 0));
      if (k == 16) begin
        check_output("full_mem_ready", 64'(wb.mem_ready), 64'd0);
        check_output("full_lq_count", 64'(wb.lq_count), 64'd4);
      end
      if (k == 17)
        check_output("after_pop_mem_ready", 64'(wb.mem_ready), 64'd1);
      if (wb.alu_ready) begin
        exp_alu_q.push_back('{rd: wb.alu_rd, val: wb.alu_result});
        alu_i++;
      end
      if (wb.mem_ready) begin
        exp_load_q.push_back('{rd: wb.mem_rd, val: wb.mem_data});
        load_i++;
      end
    end
  endtask

  // Every raised write enable must match the oldest outstanding result of its source.
  always @(negedge clk) begin
    wr_t e;
    if (wb.write_sig === 1'b1) begin
      if (exp_load_q.size() != 0 && wb.write_reg == exp_load_q[0].rd) begin
        e = exp_load_q.pop_front();
        check_output("load_write_val", wb.write_val, e.val);
      end else if (exp_alu_q.size() != 0) begin
        e = exp_alu_q.pop_front();
        check_output("alu_write_reg", 64'(wb.write_reg), 64'(e.rd));
        check_output("alu_write_val", wb.write_val, e.val);
      end else begin
        check_output("unexpected_write_sig", 64'(wb.write_sig), 64'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    wb.alu_valid = 1'b0; wb.alu_rd = '0; wb.alu_result = '0;
    wb.mem_valid = 1'b0; wb.mem_rd = '0; wb.mem_data = '0; wb.mem_funct3 = '0; wb.mem_offset = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_alu_ready", 64'(wb.alu_ready), 64'd0);
    check_output("rst_mem_ready", 64'(wb.mem_ready), 64'd0);
    check_output("rst_write_sig", 64'(wb.write_sig), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_output("idle_write_reg", 64'(wb.write_reg), 64'd0);
    check_output("idle_write_val", wb.write_val, 64'd0);
    check_output("idle_lq_count", 64'(wb.lq_count), 64'd0);
    check_output("idle_alu_ready", 64'(wb.alu_ready), 64'd1);
    check_output("idle_mem_ready", 64'(wb.mem_ready), 64'd1);

    // Single ALU op: one cycle from acceptance to write.
    apply_stimulus(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0, 3'd0, 3'd0);
    @(negedge clk);
    check_output("alu1_ready", 64'(wb.alu_ready), 64'd1);
    exp_alu_q.push_back('{rd: 5'd5, val: 64'h1234});
    apply_idle();
    @(negedge clk);
    check_output("alu1_write_sig", 64'(wb.write_sig), 64'd1);
    check_output("alu1_write_reg", 64'(wb.write_reg), 64'd5);
    check_output("alu1_write_val", wb.write_val, 64'h1234);
    apply_idle();
    @(negedge clk);
    check_output("alu1_write_sig_drop", 64'(wb.write_sig), 64'd0);

    // Load extraction: two cycles from acceptance to write.
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'(10 + i), 64'h80FF_0000_0000_0000, f3_tab[i], off_tab[i]);
      @(negedge clk);
      check_output($sformatf("ext%0d_mem_ready", i), 64'(wb.mem_ready), 64'd1);
      exp_load_q.push_back('{rd: 5'(10 + i), val: ext_tab[i]});
      apply_idle();
      @(negedge clk);
      check_output($sformatf("ext%0d_lq_count", i), 64'(wb.lq_count), 64'd1);
      check_output($sformatf("ext%0d_early_sig", i), 64'(wb.write_sig), 64'd0);
      apply_idle();
      @(negedge clk);
      check_output($sformatf("ext%0d_write_sig", i), 64'(wb.write_sig), 64'd1);
      check_output($sformatf("ext%0d_write_val", i), wb.write_val, ext_tab[i]);
    end

    // x0 destinations are consumed without raising the write enable.
    apply_stimulus(1'b1, 5'd0, 64'hDEAD, 1'b0, 5'd0, 64'd0, 3'd0, 3'd0);
    @(negedge clk);
    check_output("x0_alu_ready", 64'(wb.alu_ready), 64'd1);
    apply_idle();
    @(negedge clk);
    check_output("x0_alu_write_sig", 64'(wb.write_sig), 64'd0);
    check_output("x0_alu_write_val", wb.write_val, 64'hDEAD);
    apply_stimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'h55, 3'd3, 3'd0);
    @(negedge clk);
    check_output("x0_mem_ready", 64'(wb.mem_ready), 64'd1);
    apply_idle();
    @(negedge clk);
    check_output("x0_lq_count_1", 64'(wb.lq_count), 64'd1);
    apply_idle();
    @(negedge clk);
    check_output("x0_lq_count_0", 64'(wb.lq_count), 64'd0);
    check_output("x0_load_write_sig", 64'(wb.write_sig), 64'd0);
    check_output("x0_load_write_val", wb.write_val, 64'h55);

    // Starvation bound and queue full under sustained contention, then drain.
    run_stream(25);
    apply_idle();
    begin
      int guard = 0;
      while (wb.lq_count != 0 && guard < 20) begin
        @(negedge clk);
        guard++;
      end
    end
    check_output("drain_lq_count", 64'(wb.lq_count), 64'd0);
    repeat (3) @(negedge clk);
    check_output("drain_load_q_left", 64'(exp_load_q.size()), 64'd0);
    check_output("drain_alu_q_left", 64'(exp_alu_q.size()), 64'd0);

    // Reset with three loads queued and an ALU write in flight.
    run_stream(11);
    @(posedge clk);
    #1;
    reset = 1'b1;
    wb.alu_valid = 1'b0;
    wb.mem_valid = 1'b0;
    exp_load_q.delete();
    @(negedge clk);
    check_output("midrst_lq_count", 64'(wb.lq_count), 64'd3);
    check_output("midrst_write_sig", 64'(wb.write_sig), 64'd1);
    check_output("midrst_alu_ready", 64'(wb.alu_ready), 64'd0);
    check_output("midrst_mem_ready", 64'(wb.mem_ready), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_output("postrst_lq_count", 64'(wb.lq_count), 64'd0);
    check_output("postrst_write_sig", 64'(wb.write_sig), 64'd0);
    repeat (8) @(negedge clk);
    check_output("postrst_alu_q_left", 64'(exp_alu_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end
endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Writeback stage directly upstream of the register file; sole driver of its write port (write_sig, write_reg, write_val).
- Merges two completion streams into at most one register write per cycle:
  - ALU results, single-cycle producers.
  - Load results, which arrive late from memory.
- Load results are byte-lane extracted, sign/zero extended, then buffered in a small load queue.
- A bounded-starvation arbiter gives load drain priority while guaranteeing ALU progress.

Parameters:
- LQ_DEPTH, 4, load queue entries; power of two, ≥2.
- STARVE_LIMIT, 4, max consecutive load-queue grants while ALU is waiting; ≥1.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- alu_valid  input  1  ALU result valid
- alu_ready  output  1  ALU result accepted this cycle when alu_valid && alu_ready
- alu_rd  input  5  destination register
- alu_result  input  64  value to write
- mem_valid  input  1  load response valid
- mem_ready  output  1  load response accepted when mem_valid && mem_ready
- mem_rd  input  5  load destination register
- mem_data  input  64  aligned doubleword from memory
- mem_funct3  input  3  load type (RV64 funct3)
- mem_offset  input  3  byte offset of load within doubleword
- write_sig  output  1  register file write enable (registered)
- write_reg  output  5  register index (registered)
- write_val  output  64  write data (registered)
- lq_count  output  $clog2(LQ_DEPTH+1)  current load queue occupancy

Behaviour:
- Reset (sync, active-high):
  - Queue flushed; lq_count=0; starvation counter=0.
  - write_sig=0, write_reg=0, write_val=0.
  - alu_ready=0 and mem_ready=0 while reset is high.
  - Reset mid-operation discards all queued loads and any pending output write.
- Load extraction, done at enqueue:
  - shifted = mem_data >> (8*mem_offset); bytes shifted in from above are 0.
  - funct3 000 LB: sign-extend shifted[7:0].
  - 001 LH: sign-extend shifted[15:0].
  - 010 LW: sign-extend shifted[31:0].
  - 011 LD: shifted.
  - 100 LBU: zero-extend [7:0].
  - 101 LHU: zero-extend [15:0].
  - 110 LWU: zero-extend [31:0].
  - 111: treated as LD.
  - The queue stores {rd, 64-bit final value}.
- Load queue:
  - FIFO with wrap-around pointers.
  - mem_ready = !reset && (lq_count != LQ_DEPTH). Combinational from count; no same-cycle pop credit.
  - Push and pop in the same cycle leave lq_count unchanged.
- Arbiter (combinational, each cycle):
  - grant_alu = alu_valid && (lq_count==0 || starve==STARVE_LIMIT).
  - grant_lq = lq_count!=0 && !grant_alu; this pops the head.
  - alu_ready = !reset && (lq_count==0 || starve==STARVE_LIMIT). Asserted independent of alu_valid.
- Starvation counter:
  - Increments when grant_lq && alu_valid.
  - Clears to 0 when grant_alu or when !alu_valid.
  - Saturates at STARVE_LIMIT.
- Output register, loaded at each clock edge from the granted source:
  - write_reg = rd; write_val = value.
  - write_sig = 1 unless rd==0.
  - x0 writes consume the grant (the entry is popped or the ALU result accepted) but leave write_sig=0; write_val/write_reg still update.
  - No grant: write_sig=0; write_reg/write_val hold their previous values.
- Latency:
  - ALU accepted in cycle N → write_sig=1 in cycle N+1.
  - Load accepted in cycle N into an empty queue with no ALU contention → popped in N+1 → write_sig=1 in N+2.
- Throughput: exactly one write per cycle maximum; the block never issues two writes in one cycle.
- Ordering:
  - Loads retire in acceptance order.
  - No ordering is enforced between the ALU and load streams; the issue stage guarantees no WAW between them.

Test Plan:
- Reset then single ALU op: alu_valid=1, rd=5, result=0x1234 in cycle 1 → alu_ready=1; cycle 2 write_sig=1, write_reg=5, write_val=0x1234; cycle 3 write_sig=0.
- Load extension: mem_data=0x80FF_0000_0000_0000, mem_offset=6:
  - LB → write_val=0xFFFF_FFFF_FFFF_FFFF.
  - LBU → 0xFF.
  - LH → 0xFFFF_FFFF_FFFF_80FF.
  - LHU → 0x80FF.
  - Same data, LW at offset 4 → 0xFFFF_FFFF_80FF_0000.
- Queue full: hold alu_valid=1 with starve-free ALU, push 4 loads with distinct rd → lq_count=4, mem_ready=0; the fifth load is held and accepted only after the first pop. All loads write in order.
- Starvation bound, STARVE_LIMIT=4: queue kept non-empty, alu_valid held high → exactly 4 load writes, then 1 ALU write, repeating; alu_ready high only on every 5th cycle.
- x0 suppression: ALU rd=0 and load rd=0 → both consumed (alu_ready handshake completes, lq_count decrements); write_sig stays 0 throughout.
- Reset mid-operation: 3 loads queued plus an ALU write in the output register, assert reset one cycle → lq_count=0, write_sig=0 next cycle; no queued load is ever written afterwards.
